uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between N byte requesters using round-robin arbitration.
- Captures the winning byte, drives the transmitter's write strobe and data bus, and tracks the transmitter-ready flag through accept and reload.
- Acknowledges the requester once its byte has been accepted by the transmitter.
- Sits between the packet/command sources and the UART transmitter, in the mclkx16 domain.

---
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N byte requesters.
// Strobe rises 1 cycle after the request is seen; requests wait while the synchronised tx_rdy is low and are held until ack.
module uart_tx_arbiter #(
    parameter int N          = 4,
    parameter int WRITE_HOLD = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                 mclkx16,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    input  logic [8*N-1:0]       req_data,
    output logic [N-1:0]         ack,
    output logic                 tx_write,
    output logic [7:0]           tx_data,
    input  logic                 tx_rdy,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner,
    output logic                 err_timeout
);

    localparam int OW = $clog2(N);
    localparam int HW = $clog2(WRITE_HOLD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT_LO, WAIT_HI} state_t;

    state_t        state;
    logic          rdy_m;
    logic          rdy_s;
    logic [OW-1:0] last;
    logic [OW-1:0] cand;
    logic [OW-1:0] winner;
    logic          found;
    logic [7:0]    win_byte;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] tcnt;

    // tx_rdy lives in the txclk domain; idle-high so reset does not look like a latch event
    always_ff @(posedge mclkx16 or negedge reset_n) begin
        if (!reset_n) begin
            rdy_m <= 1'b1;
            rdy_s <= 1'b1;
        end else begin
            rdy_m <= tx_rdy;
            rdy_s <= rdy_m;
        end
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= N; k++) begin
            cand = OW'((int'(last) + k) % N);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        win_byte = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (winner == OW'(i)) win_byte = req_data[8*i +: 8];
        end
    end

    always_ff @(posedge mclkx16 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ack         <= '0;
            tx_write    <= 1'b0;
            tx_data     <= 8'h00;
            busy        <= 1'b0;
            owner       <= '0;
            err_timeout <= 1'b0;
            last        <= OW'(N - 1);
            hold_cnt    <= '0;
            tcnt        <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (rdy_s && found) begin
                        tx_data  <= win_byte;
                        owner    <= winner;
                        last     <= winner;
                        tx_write <= 1'b1;
                        hold_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (hold_cnt == HW'(WRITE_HOLD - 1)) begin
                        tx_write <= 1'b0;
                        tcnt     <= '0;
                        state    <= WAIT_LO;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!rdy_s) begin
                        ack[owner] <= 1'b1;
                        tcnt       <= '0;
                        state      <= WAIT_HI;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        // transmitter never took the byte: give up without acking
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (rdy_s) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of byte transfers plus hand-written corner sequences.
module tb_uart_tx_arbiter;

    logic        mclkx16 = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_write;
    logic [7:0]  tx_data;
    logic        tx_rdy;
    logic        busy;
    logic [1:0]  owner;
    logic        err_timeout;

    int nvec    = 0;
    int nfail   = 0;
    int ack_cnt = 0;

    always #5 mclkx16 = ~mclkx16;

    uart_tx_arbiter #(.N(4), .WRITE_HOLD(2), .TIMEOUT(64)) dut (
        .mclkx16     (mclkx16),
        .reset_n     (reset_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .tx_write    (tx_write),
        .tx_data     (tx_data),
        .tx_rdy      (tx_rdy),
        .busy        (busy),
        .owner       (owner),
        .err_timeout (err_timeout)
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [1:0]  own;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge mclkx16) begin
        if (reset_n) begin
            if (ack != 4'b0000) ack_cnt++;
            if ($countones(ack) > 1) begin
                nfail++;
                $display("FAIL ack_multi: got %b, expected at most one bit set", ack);
            end
        end
    end

    task automatic check_reset();
        chk("rst_ack", ack, 0);
        chk("rst_tx_write", tx_write, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_err", err_timeout, 0);
    endtask

    task automatic grant(input logic [3:0] r, input logic [31:0] d, input logic [1:0] own,
                         input logic [7:0] exp_d, input int lat, input bit rel);
        int n;
        int w;
        req      = r;
        req_data = d;
        if (rel) tx_rdy = 1'b1;
        n = 0;
        do begin
            @(negedge mclkx16);
            n++;
        end while (!tx_write && n < 20);
        chk("grant_latency", n, lat);
        chk("owner", owner, own);
        chk("tx_data", tx_data, exp_d);
        chk("busy_set", busy, 1);
        w = 0;
        while (tx_write && w < 20) begin
            w++;
            @(negedge mclkx16);
        end
        chk("write_hold", w, 2);
    endtask

    task automatic accept(input logic [1:0] own, input logic [7:0] exp_d);
        int n;
        logic [3:0] e;
        e      = 4'b0001 << own;
        tx_rdy = 1'b0;
        n = 0;
        do begin
            @(negedge mclkx16);
            n++;
        end while (ack == 4'b0000 && n < 20);
        chk("ack_latency", n, 3);
        chk("ack_owner", ack, e);
        chk("tx_data_hold", tx_data, exp_d);
        req[own] = 1'b0;
        @(negedge mclkx16);
        chk("ack_single", ack, 0);
    endtask

    task automatic finish_xfer();
        int n;
        tx_rdy = 1'b1;
        n = 0;
        do begin
            @(negedge mclkx16);
            n++;
        end while (busy && n < 20);
        chk("busy_clear", busy, 0);
    endtask

    initial begin
        int n;
        int nh;
        int acks_before;

        tbl[0]  = '{4'b1111, 32'h0D0C0B0A, 2'd0, 8'h0A};
        tbl[1]  = '{4'b1111, 32'h1D1C1B1A, 2'd1, 8'h1B};
        tbl[2]  = '{4'b1111, 32'h2D2C2B2A, 2'd2, 8'h2C};
        tbl[3]  = '{4'b1111, 32'h3D3C3B3A, 2'd3, 8'h3D};
        tbl[4]  = '{4'b1111, 32'h4D4C4B4A, 2'd0, 8'h4A};
        tbl[5]  = '{4'b0010, 32'h5D5C5B5A, 2'd1, 8'h5B};
        tbl[6]  = '{4'b1001, 32'h6D6C6B6A, 2'd3, 8'h6D};
        tbl[7]  = '{4'b0001, 32'h7D7C7B7A, 2'd0, 8'h7A};
        tbl[8]  = '{4'b0100, 32'h8DA58B8A, 2'd2, 8'hA5};
        tbl[9]  = '{4'b0001, 32'h9D9C9B9A, 2'd0, 8'h9A};
        tbl[10] = '{4'b1000, 32'hADACABAA, 2'd3, 8'hAD};
        tbl[11] = '{4'b0011, 32'hBDBCBBBA, 2'd0, 8'hBA};

        reset_n  = 1'b0;
        tx_rdy   = 1'b1;
        req      = 4'b0000;
        req_data = 32'h0;
        repeat (2) @(negedge mclkx16);
        check_reset();
        reset_n = 1'b1;
        @(negedge mclkx16);

        for (int i = 0; i < 12; i++) begin
            grant(tbl[i].req, tbl[i].data, tbl[i].own, tbl[i].exp_data, 1, 1'b0);
            accept(tbl[i].own, tbl[i].exp_data);
            finish_xfer();
        end
        req = 4'b0000;

        // transmitter not ready: request must wait for the synchronised ready
        tx_rdy = 1'b0;
        repeat (3) @(negedge mclkx16);
        req      = 4'b0010;
        req_data = 32'hC4C3C2C1;
        nh = 0;
        repeat (6) begin
            @(negedge mclkx16);
            if (tx_write || busy) nh++;
        end
        chk("notready_hold", nh, 0);
        grant(4'b0010, 32'hC4C3C2C1, 2'd1, 8'hC2, 3, 1'b1);
        accept(2'd1, 8'hC2);
        finish_xfer();

        // stuck transmitter: ready never drops after the strobe
        acks_before = ack_cnt;
        grant(4'b0100, 32'hD4D3D2D1, 2'd2, 8'hD3, 1, 1'b0);
        n = 0;
        do begin
            @(negedge mclkx16);
            n++;
        end while (!err_timeout && n < 100);
        chk("timeout_cycles", n, 64);
        chk("timeout_idle", busy, 0);
        chk("timeout_no_ack", ack_cnt, acks_before);
        req = 4'b0000;
        @(negedge mclkx16);
        grant(4'b1000, 32'hE4E3E2E1, 2'd3, 8'hE4, 1, 1'b0);
        accept(2'd3, 8'hE4);
        finish_xfer();
        chk("err_sticky", err_timeout, 1);

        // asynchronous reset while waiting for ready to return
        grant(4'b0010, 32'hF4F3F2F1, 2'd1, 8'hF2, 1, 1'b0);
        accept(2'd1, 8'hF2);
        chk("wait_hi_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset();
        tx_rdy = 1'b1;
        req    = 4'b0000;
        @(negedge mclkx16);
        reset_n = 1'b1;
        @(negedge mclkx16);
        grant(4'b0011, 32'h04030201, 2'd0, 8'h01, 1, 1'b0);
        accept(2'd0, 8'h01);
        finish_xfer();

        chk("ack_total", ack_cnt, 16);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
